crt_param_sequencer: RTL and testbench
======================================

Name: crt_param_sequencer

Overview:
Sequences the shared 32-bit inverse engine (n0prime/qinv datapath) to produce the three CRT decryption constants for one key pair (p, q): n0p = -p^-1 mod 2^32, n0q = -q^-1 mod 2^32, and qinv = q^-1 mod p. The block sits between the key-load logic and the engine. It latches operands, issues three engine jobs in fixed order, collects the results into output registers, and reports done or error. It owns the engine exclusively while busy.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 4096, max cycles allowed per engine job before a timeout error
TW, 13, width of the watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
p  in  WIDTH  prime p; latched on accepted start
q  in  WIDTH  prime q; latched on accepted start
busy  out  1  high from the cycle after an accepted start until done/err asserts
done  out  1  one-cycle pulse; results valid
err  out  1  one-cycle pulse; err_code valid
err_code  out  2  01 even/zero operand, 10 engine reported no inverse, 11 timeout; held until next accepted start
n0p  out  WIDTH  -p^-1 mod 2^WIDTH
n0q  out  WIDTH  -q^-1 mod 2^WIDTH
qinv  out  WIDTH  q^-1 mod p
eng_start  out  1  one-cycle job launch to engine
eng_mode  out  1  0 = n0prime of eng_a, 1 = eng_a^-1 mod eng_m
eng_a  out  WIDTH  engine operand
eng_m  out  WIDTH  engine modulus (mode 1 only; 0 in mode 0)
eng_done  in  1  engine job-complete pulse
eng_err  in  1  qualifies eng_done: no inverse exists
eng_result  in  WIDTH  engine result, valid with eng_done

Behaviour:
- Reset: state IDLE. busy, done, err, eng_start, eng_mode = 0. err_code, n0p, n0q, qinv, eng_a, eng_m = 0. Watchdog = 0. Reset mid-job aborts immediately; any later eng_done is ignored in IDLE.
- States: IDLE, CHECK, JP_GO, JP_WAIT, JQ_GO, JQ_WAIT, JI_GO, JI_WAIT, FIN, FAIL.
- IDLE: when start=1, latch p/q into pr/qr and go to CHECK. start in any other state is ignored; no queueing.
- CHECK (1 cycle): if pr[0]=0 or qr[0]=0, or pr=0, set code 01 and go to FAIL. Otherwise go to JP_GO.
- JP_GO (1 cycle): eng_start=1, eng_mode=0, eng_a=pr, eng_m=0. Go to JP_WAIT.
- JP_WAIT: on eng_done, capture eng_result into n0p and go to JQ_GO.
- JQ_GO / JQ_WAIT: same as the p job with eng_a=qr. The result goes to n0q.
- JI_GO / JI_WAIT: eng_mode=1, eng_a=qr, eng_m=pr. The result goes to qinv.
- In any WAIT state, eng_done with eng_err=1 sets code 10 and goes to FAIL. eng_a, eng_m and eng_mode hold stable from GO until eng_done.
- Watchdog: cleared in each GO state and incremented each WAIT cycle. When it reaches TIMEOUT with no eng_done, set code 11 and go to FAIL. If eng_done arrives in the same cycle the count hits TIMEOUT, eng_done wins.
- FIN: done=1 for one cycle, busy=0, then IDLE. n0p, n0q and qinv hold until the next accepted start.
- FAIL: err=1 for one cycle and err_code updated, then IDLE. Result registers from completed jobs hold; unfinished ones keep their previous values. The accepted start clears all result registers to 0.
- busy=1 in CHECK through the last WAIT; done/err assert with busy=0.
- Latency with engine latency L per job: done arrives 3*(L+1)+2 cycles after the start cycle. Example: L=1 gives done in cycle start+8.
- eng_done in IDLE, CHECK or a GO state is ignored.

Test Plan:
- p=5, q=3, engine model L=4 -> eng_start pulses three times in order (mode 0/a=5, mode 0/a=3, mode 1/a=3,m=5). done in cycle start+17 with n0p=0x33333333, n0q=0x55555555, qinv=2.
- p=61, q=53, back-to-back second start during busy -> second start ignored. Single done with qinv=38; exactly three eng_start pulses.
- p=6, q=3 -> no eng_start. err pulse in cycle start+2, err_code=01, n0p/n0q/qinv=0.
- p=5, q=3, engine returns eng_err on the third job -> err with code 10. n0p=0x33333333 and n0q=0x55555555 retained, qinv=0.
- Engine never responds on the second job, TIMEOUT=16 -> err with code 11 exactly 16 WAIT cycles after the second eng_start. A new start afterward completes normally.
- reset asserted during JQ_WAIT, then a stray eng_done the cycle after -> all outputs 0, state IDLE, no done/err. A subsequent run with p=5, q=3 produces correct results.

Source files
------------

// File: rtl/crt_param_sequencer.sv
// Purpose: sequences the shared inverse engine to build n0p, n0q and qinv for one (p, q) key pair.
// Latency: done/err is a registered state decode; done lands 3*(L+1)+2 cycles after start for engine latency L.
// Backpressure: start is taken only in IDLE (no queueing); each engine job is bounded by a watchdog.
module crt_param_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [WIDTH-1:0] n0p,
    output logic [WIDTH-1:0] n0q,
    output logic [WIDTH-1:0] qinv,
    output logic             eng_start,
    output logic             eng_mode,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_m,
    input  logic             eng_done,
    input  logic             eng_err,
    input  logic [WIDTH-1:0] eng_result
);

    typedef enum logic [3:0] {
        IDLE, CHECK, JP_GO, JP_WAIT, JQ_GO, JQ_WAIT, JI_GO, JI_WAIT, FIN, FAIL
    } state_t;

    localparam logic [1:0] CODE_OPERAND = 2'b01;
    localparam logic [1:0] CODE_NOINV   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] qr;
    logic [TW-1:0]    wd;
    logic             in_wait;
    logic             wd_expire;
    logic             accept;
    logic             set_code;
    logic [1:0]       code_nxt;

    assign in_wait   = (state == JP_WAIT) || (state == JQ_WAIT) || (state == JI_WAIT);
    // The count reaches TIMEOUT at the end of this cycle; a same-cycle eng_done still wins.
    assign wd_expire = (wd == TW'(TIMEOUT - 1));
    assign accept    = (state == IDLE) && start;

    // Next-state and Moore outputs; engine operands are decoded from state so they hold from GO to eng_done.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        eng_start = 1'b0;
        eng_mode  = 1'b0;
        eng_a     = '0;
        eng_m     = '0;
        set_code  = 1'b0;
        code_nxt  = 2'b00;

        case (state)
            IDLE: begin
                if (start) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (!pr[0] || !qr[0] || (pr == '0)) begin
                    set_code  = 1'b1;
                    code_nxt  = CODE_OPERAND;
                    state_nxt = FAIL;
                end else begin
                    state_nxt = JP_GO;
                end
            end
            JP_GO: begin
                busy      = 1'b1;
                eng_start = 1'b1;
                eng_a     = pr;
                state_nxt = JP_WAIT;
            end
            JP_WAIT: begin
                busy  = 1'b1;
                eng_a = pr;
                if (eng_done) state_nxt = JQ_GO;
            end
            JQ_GO: begin
                busy      = 1'b1;
                eng_start = 1'b1;
                eng_a     = qr;
                state_nxt = JQ_WAIT;
            end
            JQ_WAIT: begin
                busy  = 1'b1;
                eng_a = qr;
                if (eng_done) state_nxt = JI_GO;
            end
            JI_GO: begin
                busy      = 1'b1;
                eng_start = 1'b1;
                eng_mode  = 1'b1;
                eng_a     = qr;
                eng_m     = pr;
                state_nxt = JI_WAIT;
            end
            JI_WAIT: begin
                busy     = 1'b1;
                eng_mode = 1'b1;
                eng_a    = qr;
                eng_m    = pr;
                if (eng_done) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            FAIL: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Failure exits shared by all three WAIT states.
        if (in_wait) begin
            if (eng_done) begin
                if (eng_err) begin
                    set_code  = 1'b1;
                    code_nxt  = CODE_NOINV;
                    state_nxt = FAIL;
                end
            end else if (wd_expire) begin
                set_code  = 1'b1;
                code_nxt  = CODE_TIMEOUT;
                state_nxt = FAIL;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Operand latch on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            pr <= '0;
            qr <= '0;
        end else if (accept) begin
            pr <= p;
            qr <= q;
        end
    end

    // Per-job watchdog: zero outside WAIT (so every GO clears it), counts each WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset)        wd <= '0;
        else if (in_wait) wd <= wd + 1'b1;
        else              wd <= '0;
    end

    // Error code: cleared by an accepted start, written on entry to FAIL, otherwise held.
    always_ff @(posedge clk) begin
        if (reset)         err_code <= 2'b00;
        else if (accept)   err_code <= 2'b00;
        else if (set_code) err_code <= code_nxt;
    end

    // Result registers: cleared by an accepted start, each loaded by its own job's clean completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            n0p  <= '0;
            n0q  <= '0;
            qinv <= '0;
        end else if (accept) begin
            n0p  <= '0;
            n0q  <= '0;
            qinv <= '0;
        end else if (eng_done && !eng_err) begin
            case (state)
                JP_WAIT: n0p  <= eng_result;
                JQ_WAIT: n0q  <= eng_result;
                JI_WAIT: qinv <= eng_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crt_param_sequencer.sv
// Purpose: directed bench for crt_param_sequencer with a latency/fault-configurable engine responder.
// Latency: DUT built with TIMEOUT=16; expected done/err cycles are counted from the start cycle.
// Backpressure: engine responder can delay, report no-inverse, hang a job, or inject a stray eng_done.
module tb_crt_param_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] p;
    logic [31:0] q;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] n0p;
    logic [31:0] n0q;
    logic [31:0] qinv;
    logic        eng_start;
    logic        eng_mode;
    logic [31:0] eng_a;
    logic [31:0] eng_m;
    logic        eng_done;
    logic        eng_err;
    logic [31:0] eng_result;

    crt_param_sequencer #(.WIDTH(32), .TIMEOUT(16), .TW(13)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .p          (p),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .n0p        (n0p),
        .n0q        (n0q),
        .qinv       (qinv),
        .eng_start  (eng_start),
        .eng_mode   (eng_mode),
        .eng_a      (eng_a),
        .eng_m      (eng_m),
        .eng_done   (eng_done),
        .eng_err    (eng_err),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Engine behaviour controls (written by the main sequence only).
    int   eng_lat   = 1;
    int   err_job   = 0;
    int   hang_job  = 0;
    int   run_base  = 0;
    logic stray_req = 1'b0;

    // Engine state and job log (written by the responder only).
    int          njobs = 0;
    logic        pend;
    int          rem;
    logic        cur_err;
    logic [31:0] cur_res;
    logic        log_mode [0:63];
    logic [31:0] log_a    [0:63];
    logic [31:0] log_m    [0:63];

    function automatic logic [31:0] inv32(input logic [31:0] a);
        logic [31:0] x;
        x = a;
        repeat (5) x = x * (32'd2 - a * x);
        return x;
    endfunction

    function automatic logic [31:0] modinv(input logic [31:0] a, input logic [31:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 1; i < 4096; i++) begin
            if ((longint'(i) < longint'(m)) && (r == '0) &&
                (((longint'(a) * longint'(i)) % longint'(m)) == 1)) r = 32'(i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine responder: acts just after each falling edge so the main sequence's control writes are settled.
    initial begin
        eng_done   = 1'b0;
        eng_err    = 1'b0;
        eng_result = '0;
        pend       = 1'b0;
        rem        = 0;
        cur_err    = 1'b0;
        cur_res    = '0;
        forever begin
            @(negedge clk);
            #1;
            eng_done   = 1'b0;
            eng_err    = 1'b0;
            eng_result = '0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (stray_req) begin
                    eng_done   = 1'b1;
                    eng_result = 32'hDEADBEEF;
                end
                if (pend) begin
                    rem--;
                    if (rem <= 0) begin
                        pend       = 1'b0;
                        eng_done   = 1'b1;
                        eng_err    = cur_err;
                        eng_result = cur_res;
                    end
                end
                if (eng_start) begin
                    if (njobs < 64) begin
                        log_mode[njobs] = eng_mode;
                        log_a[njobs]    = eng_a;
                        log_m[njobs]    = eng_m;
                    end
                    njobs++;
                    cur_err = ((njobs - run_base) == err_job);
                    cur_res = eng_mode ? modinv(eng_a, eng_m) : (32'd0 - inv32(eng_a));
                    if ((njobs - run_base) != hang_job) begin
                        pend = 1'b1;
                        rem  = eng_lat;
                    end
                end
            end
        end
    end

    // Issue one start and watch until done/err; optionally re-pulse start while busy.
    task automatic run(input logic [31:0] pp, input logic [31:0] qq, input int restart_at,
                       input int max, output int k_end, output logic sd, output logic se);
        @(negedge clk);
        start    = 1'b1;
        p        = pp;
        q        = qq;
        run_base = njobs;
        k_end    = 0;
        sd       = 1'b0;
        se       = 1'b0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (k == restart_at) begin
                p = 32'd7;
                q = 32'd9;
            end
            if (k == 1) chk("busy_after_start", 32'(busy), 1);
            if (done || err) begin
                k_end = k;
                sd    = done;
                se    = err;
                chk("busy_low_at_end", 32'(busy), 0);
                break;
            end
        end
        start = 1'b0;
        if (k_end == 0) chk("end_within_bound", 32'(done | err), 1);
    endtask

    initial begin
        int   k;
        int   b;
        int   extra;
        logic sd;
        logic se;

        reset = 1'b1;
        start = 1'b0;
        p     = '0;
        q     = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'({busy, done, err, eng_start, eng_mode, err_code}), 0);
        chk("rst_n0p", n0p, 0);
        chk("rst_n0q", n0q, 0);
        chk("rst_qinv", qinv, 0);
        chk("rst_eng_am", eng_a | eng_m, 0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal run, engine latency 4.
        eng_lat = 4;
        run(32'd5, 32'd3, 0, 100, k, sd, se);
        b = run_base;
        chk("t1_latency", k, 17);
        chk("t1_done", 32'(sd), 1);
        chk("t1_err", 32'(se), 0);
        chk("t1_n0p", n0p, 32'h33333333);
        chk("t1_n0q", n0q, 32'h55555555);
        chk("t1_qinv", qinv, 2);
        chk("t1_jobs", njobs - b, 3);
        chk("t1_modes", 32'({log_mode[b], log_mode[b+1], log_mode[b+2]}), 1);
        chk("t1_j1_a", log_a[b], 5);
        chk("t1_j1_m", log_m[b], 0);
        chk("t1_j2_a", log_a[b+1], 3);
        chk("t1_j3_a", log_a[b+2], 3);
        chk("t1_j3_m", log_m[b+2], 5);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(done), 0);
        chk("t1_n0p_hold", n0p, 32'h33333333);

        // Second start while busy must be ignored.
        eng_lat = 2;
        run(32'd61, 32'd53, 3, 100, k, sd, se);
        b = run_base;
        chk("t2_latency", k, 11);
        chk("t2_done", 32'(sd), 1);
        chk("t2_qinv", qinv, 38);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            extra += int'(done) + int'(err) + int'(eng_start) + int'(busy);
        end
        chk("t2_no_second_run", extra, 0);
        chk("t2_jobs", njobs - b, 3);

        // Operand checks: even p, even q, zero p.
        eng_lat = 1;
        run(32'd6, 32'd3, 0, 20, k, sd, se);
        chk("t3_latency", k, 2);
        chk("t3_err", 32'(se), 1);
        chk("t3_code", 32'(err_code), 1);
        chk("t3_results_cleared", n0p | n0q | qinv, 0);
        chk("t3_no_jobs", njobs - run_base, 0);
        run(32'd5, 32'd4, 0, 20, k, sd, se);
        chk("t3b_q_even", 32'({se, err_code}), 32'b101);
        run(32'd0, 32'd3, 0, 20, k, sd, se);
        chk("t3c_p_zero", 32'({se, err_code}), 32'b101);

        // Engine reports no inverse on the third job.
        err_job = 3;
        run(32'd5, 32'd3, 0, 50, k, sd, se);
        err_job = 0;
        chk("t4_latency", k, 8);
        chk("t4_err", 32'(se), 1);
        chk("t4_code", 32'(err_code), 2);
        chk("t4_n0p", n0p, 32'h33333333);
        chk("t4_n0q", n0q, 32'h55555555);
        chk("t4_qinv", qinv, 0);

        // Engine hangs on the second job: timeout after 16 WAIT cycles.
        hang_job = 2;
        run(32'd5, 32'd3, 0, 100, k, sd, se);
        hang_job = 0;
        chk("t5_latency", k, 21);
        chk("t5_err", 32'(se), 1);
        chk("t5_code", 32'(err_code), 3);
        chk("t5_n0p", n0p, 32'h33333333);
        chk("t5_n0q", n0q, 0);
        run(32'd5, 32'd3, 0, 50, k, sd, se);
        chk("t5_recover_latency", k, 8);
        chk("t5_recover_qinv", qinv, 2);
        chk("t5_recover_code", 32'(err_code), 0);

        // eng_done on the cycle the count hits TIMEOUT wins; one cycle later times out.
        eng_lat = 16;
        run(32'd5, 32'd3, 0, 200, k, sd, se);
        chk("t5b_latency", k, 53);
        chk("t5b_done", 32'(sd), 1);
        chk("t5b_n0q", n0q, 32'h55555555);
        eng_lat = 17;
        run(32'd5, 32'd3, 0, 200, k, sd, se);
        chk("t5c_latency", k, 19);
        chk("t5c_code", 32'({se, err_code}), 32'b111);
        chk("t5c_n0p", n0p, 0);

        // Reset during JQ_WAIT, then a stray eng_done in IDLE.
        eng_lat  = 1;
        hang_job = 2;
        @(negedge clk);
        start    = 1'b1;
        p        = 32'd5;
        q        = 32'd3;
        run_base = njobs;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_in_jq_wait", 32'({busy, eng_start, eng_mode}), 32'b100);
        chk("t6_jq_a", eng_a, 3);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        hang_job  = 0;
        chk("t6_flags", 32'({busy, done, err, eng_start, eng_mode, err_code}), 0);
        chk("t6_n0p", n0p, 0);
        chk("t6_n0q_qinv", n0q | qinv, 0);
        chk("t6_eng_am", eng_a | eng_m, 0);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            extra += int'(done) + int'(err) + int'(busy);
        end
        chk("t6_idle_quiet", extra, 0);
        run(32'd5, 32'd3, 0, 50, k, sd, se);
        chk("t6_rerun_latency", k, 8);
        chk("t6_rerun_n0p", n0p, 32'h33333333);
        chk("t6_rerun_n0q", n0q, 32'h55555555);
        chk("t6_rerun_qinv", qinv, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
